// File: rtl/wb_dec_mux_pkg.sv
// Shared types and constants for the Wishbone single-master decode mux.
package wb_dec_mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DERR,
    DRAIN
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  function automatic int unsigned sel_w(input int unsigned dw);
    return dw / 8;
  endfunction

  // Width of a slave index; never below one bit so a single-slave build stays legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_dec_watchdog.sv
// Per-transfer stall counter: expires on the TIMEOUT_CYCLES-th consecutive stalled strobe cycle.
module wb_dec_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stall_i,
  input  logic clear_i,
  output logic expire_o
);

  logic [15:0] cnt_q, cnt_d;

  assign expire_o = stall_i && !clear_i && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear_i || !stall_i || expire_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_dec_mux.sv
// Single-master / N-slave Wishbone B4 decode mux with decode-miss error and stall watchdog.
// Optional error log enabled by defining WB_DEC_MUX_ERRLOG_EN.
module wb_dec_mux
  import wb_dec_mux_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 8,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = {
    32'h0000_7000, 32'h0000_6000, 32'h0000_5000, 32'h0000_4000,
    32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = {8{32'hFFFF_F000}},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [AW-1:0]              wbm_adr_i,
  input  logic [DW-1:0]              wbm_dat_i,
  input  logic [sel_w(DW)-1:0]       wbm_sel_i,
  input  logic                       wbm_we_i,
  input  logic                       wbm_cyc_i,
  input  logic                       wbm_stb_i,
  input  logic [2:0]                 wbm_cti_i,
  input  logic [1:0]                 wbm_bte_i,
  output logic [DW-1:0]              wbm_dat_o,
  output logic                       wbm_ack_o,
  output logic                       wbm_err_o,
  output logic                       wbm_rty_o,
  output logic [NUM_SLAVES*AW-1:0]   wbs_adr_o,
  output logic [NUM_SLAVES*DW-1:0]   wbs_dat_o,
  output logic [NUM_SLAVES*sel_w(DW)-1:0] wbs_sel_o,
  output logic [NUM_SLAVES-1:0]      wbs_we_o,
  output logic [NUM_SLAVES-1:0]      wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]      wbs_stb_o,
  output logic [NUM_SLAVES*3-1:0]    wbs_cti_o,
  output logic [NUM_SLAVES*2-1:0]    wbs_bte_o,
  input  logic [NUM_SLAVES*DW-1:0]   wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]      wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]      wbs_err_i,
  input  logic [NUM_SLAVES-1:0]      wbs_rty_i
`ifdef WB_DEC_MUX_ERRLOG_EN
  ,
  input  logic                       err_clr_i,
  output logic [AW-1:0]              err_adr_o,
  output logic [7:0]                 err_cnt_o
`endif
);

  localparam int unsigned IW = idx_w(NUM_SLAVES);

  state_e                state_q, state_d;
  logic [IW-1:0]         sel_q, sel_d, hit_idx, act_idx;
  logic [NUM_SLAVES-1:0] hit_vec;
  logic                  hit, req, drive, derr;
  logic                  slv_ack, slv_err, slv_rty, stall, wd_clear, expire;

  assign req = wbm_cyc_i && wbm_stb_i;

  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++)
      hit_vec[i] = (wbm_adr_i & MATCH_MASK[i*AW +: AW]) == MATCH_ADDR[i*AW +: AW];
    for (int unsigned i = NUM_SLAVES; i > 0; i--)
      if (hit_vec[i-1]) hit_idx = IW'(i - 1);
  end
  assign hit = |hit_vec;

  // Kept apart from the FSM block so the watchdog expiry does not loop back into slave selection.
  always_comb begin
    act_idx = (state_q == IDLE) ? hit_idx : sel_q;
    drive   = !wb_rst_i && (((state_q == IDLE) && req && hit) ||
                            ((state_q == ACTIVE) && wbm_cyc_i));
  end

  assign slv_ack  = wbs_ack_i[act_idx];
  assign slv_err  = wbs_err_i[act_idx];
  assign slv_rty  = wbs_rty_i[act_idx];
  assign wd_clear = !drive || !wbm_stb_i || slv_ack || slv_err || slv_rty;
  assign stall    = !wd_clear;

  wb_dec_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .stall_i (stall),
    .clear_i (wd_clear),
    .expire_o(expire)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    derr    = 1'b0;
    unique case (state_q)
      IDLE: if (req) begin
        if (hit) begin
          sel_d   = hit_idx;
          state_d = expire ? DERR : ACTIVE;
        end else begin
          state_d = DERR;
        end
      end
      ACTIVE: if (!wbm_cyc_i)  state_d = IDLE;
              else if (expire) state_d = DERR;
      DERR: begin
        derr    = wbm_cyc_i;
        state_d = wbm_cyc_i ? DRAIN : IDLE;
      end
      DRAIN: begin
        derr = req;
        if (!wbm_cyc_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    if (drive) begin
      wbs_cyc_o[act_idx] = 1'b1;
      wbs_stb_o[act_idx] = wbm_stb_i;
    end
  end

  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
  assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
  assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};

  assign wbm_dat_o = drive ? wbs_dat_i[act_idx*DW +: DW] : '0;
  assign wbm_ack_o = drive && slv_ack;
  assign wbm_rty_o = drive && slv_rty;
  assign wbm_err_o = !wb_rst_i && ((drive && slv_err) || derr);

`ifdef WB_DEC_MUX_ERRLOG_EN
  logic [AW-1:0] err_adr_q, err_adr_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          err_ev;

  assign err_ev = ((state_q == IDLE) && req && !hit) || expire;

  always_comb begin
    err_adr_d = err_adr_q;
    err_cnt_d = err_cnt_q;
    if (err_clr_i) begin
      err_adr_d = '0;
      err_cnt_d = '0;
    end else if (err_ev) begin
      if (err_cnt_q == 8'd0)   err_adr_d = wbm_adr_i;
      if (err_cnt_q != 8'hFF)  err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      err_adr_q <= err_adr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_adr_o = err_adr_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_wb_dec_mux.sv
// Directed bench for wb_dec_mux: 4 slaves on 4 KiB pages, watchdog of 4 cycles.
module tb_wb_dec_mux;
  import wb_dec_mux_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   m_adr;
  logic [DW-1:0]   m_dat_w;
  logic [3:0]      m_sel;
  logic            m_we, m_cyc, m_stb;
  logic [2:0]      m_cti;
  logic [1:0]      m_bte;
  logic [DW-1:0]   m_dat_r;
  logic            m_ack, m_err, m_rty;
  logic [N*AW-1:0] s_adr;
  logic [N*DW-1:0] s_dat_w;
  logic [N*4-1:0]  s_sel;
  logic [N-1:0]    s_we, s_cyc, s_stb;
  logic [N*3-1:0]  s_cti;
  logic [N*2-1:0]  s_bte;
  logic [N*DW-1:0] s_dat_r;
  logic [N-1:0]    s_ack, s_err, s_rty;
`ifdef WB_DEC_MUX_ERRLOG_EN
  logic            err_clr;
  logic [AW-1:0]   err_adr;
  logic [7:0]      err_cnt;
`endif

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  wb_dec_mux #(
    .NUM_SLAVES    (N),
    .AW            (AW),
    .DW            (DW),
    .MATCH_ADDR    ({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .MATCH_MASK    ({4{32'hFFFF_F000}}),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbm_adr_i(m_adr),
    .wbm_dat_i(m_dat_w),
    .wbm_sel_i(m_sel),
    .wbm_we_i (m_we),
    .wbm_cyc_i(m_cyc),
    .wbm_stb_i(m_stb),
    .wbm_cti_i(m_cti),
    .wbm_bte_i(m_bte),
    .wbm_dat_o(m_dat_r),
    .wbm_ack_o(m_ack),
    .wbm_err_o(m_err),
    .wbm_rty_o(m_rty),
    .wbs_adr_o(s_adr),
    .wbs_dat_o(s_dat_w),
    .wbs_sel_o(s_sel),
    .wbs_we_o (s_we),
    .wbs_cyc_o(s_cyc),
    .wbs_stb_o(s_stb),
    .wbs_cti_o(s_cti),
    .wbs_bte_o(s_bte),
    .wbs_dat_i(s_dat_r),
    .wbs_ack_i(s_ack),
    .wbs_err_i(s_err),
    .wbs_rty_i(s_rty)
`ifdef WB_DEC_MUX_ERRLOG_EN
    ,
    .err_clr_i(err_clr),
    .err_adr_o(err_adr),
    .err_cnt_o(err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_master();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    m_cti = CTI_CLASSIC; m_bte = BTE_LINEAR;
    s_ack = '0; s_err = '0; s_rty = '0;
  endtask

  task automatic request(input logic [AW-1:0] adr, input logic [2:0] cti);
    m_adr = adr; m_cti = cti; m_cyc = 1'b1; m_stb = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    m_adr = '0; m_dat_w = 32'h1234_5678; m_sel = 4'hF;
    s_dat_r = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
`ifdef WB_DEC_MUX_ERRLOG_EN
    err_clr = 1'b0;
`endif
    idle_master();
    tick();
    chk("reset_cyc", s_cyc, 4'b0000);
    chk("reset_resp", {m_ack, m_err, m_rty}, 3'b000);
    chk("reset_dat", m_dat_r, 32'h0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a burst to slave 2
    request(32'h0000_2000, CTI_INCR);
    #1 chk("burst2_cyc", s_cyc, 4'b0100);
    tick();
    s_ack[2] = 1'b1;
    #1 chk("burst2_ack", m_ack, 1'b1);
    rst = 1'b1;
    #1 chk("rst_mid_cyc", s_cyc, 4'b0000);
    chk("rst_mid_ack", m_ack, 1'b0);
    tick();
    rst = 1'b0;
    idle_master();
    tick();

    // Slave 1 read, acked in the third cycle
    request(32'h0000_1040, CTI_CLASSIC);
    #1 chk("rd1_stb", s_stb, 4'b0010);
    chk("rd1_adr_bcast", s_adr[3*AW +: AW], 32'h0000_1040);
    chk("rd1_noack", m_ack, 1'b0);
    tick(); tick();
    s_ack[1] = 1'b1;
    #1 chk("rd1_ack", m_ack, 1'b1);
    chk("rd1_dat", m_dat_r, 32'hCAFE_0001);
    tick();
    idle_master();
    #1 chk("rd1_release", s_cyc, 4'b0000);
    tick();

    // Decode miss, master ends the cycle on err
    request(32'h0000_5000, CTI_CLASSIC);
    #1 chk("miss_nostb", s_stb, 4'b0000);
    chk("miss_err_now", m_err, 1'b0);
    tick();
    chk("miss_err", m_err, 1'b1);
    chk("miss_nostb2", s_stb, 4'b0000);
    idle_master();
    tick();
    chk("miss_err_once", m_err, 1'b0);
`ifdef WB_DEC_MUX_ERRLOG_EN
    chk("log_cnt1", err_cnt, 8'd1);
    chk("log_adr1", err_adr, 32'h0000_5000);
`endif

    // Decode miss with cyc held: further strobe in DRAIN gets err
    request(32'h0000_5004, CTI_CLASSIC);
    tick();
    chk("drain_derr", m_err, 1'b1);
    m_stb = 1'b0;
    tick();
    chk("drain_quiet", m_err, 1'b0);
    m_stb = 1'b1;
    #1 chk("drain_err", m_err, 1'b1);
    chk("drain_nostb", s_stb, 4'b0000);
    idle_master();
    tick();

    // Watchdog: slave 2 never responds
    request(32'h0000_2000, CTI_CLASSIC);
    tick(); tick(); tick();
    chk("wd_pre_err", m_err, 1'b0);
    chk("wd_pre_cyc", s_cyc, 4'b0100);
    tick();
    chk("wd_err", m_err, 1'b1);
    chk("wd_cyc_drop", s_cyc, 4'b0000);
    m_stb = 1'b0;
    s_ack[2] = 1'b1;
    #1 chk("wd_late_ack", m_ack, 1'b0);
    tick();
    chk("wd_drain_ack", m_ack, 1'b0);
    chk("wd_drain_err", m_err, 1'b0);
    idle_master();
    tick();
`ifdef WB_DEC_MUX_ERRLOG_EN
    chk("log_cnt3", err_cnt, 8'd3);
    chk("log_adr_kept", err_adr, 32'h0000_5000);
`endif

    // INCR burst from slave 0 running past its page stays on slave 0
    s_ack[0] = 1'b1;
    for (int unsigned b = 0; b < 4; b++) begin
      request(32'h0000_0FF8 + 32'(b * 4), (b == 3) ? CTI_EOB : CTI_INCR);
      #1 chk($sformatf("burst_stb%0d", b), s_stb, 4'b0001);
      chk($sformatf("burst_ack%0d", b), m_ack, 1'b1);
      tick();
    end
    idle_master();
    tick();

    // Ack on the exact expiry cycle wins over the timeout
    request(32'h0000_3000, CTI_CLASSIC);
    tick(); tick(); tick();
    s_ack[3] = 1'b1;
    #1 chk("exp_ack", m_ack, 1'b1);
    chk("exp_noerr", m_err, 1'b0);
    chk("exp_dat", m_dat_r, 32'hCAFE_0003);
    tick();
    chk("exp_noerr_next", m_err, 1'b0);
    idle_master();
    tick();

`ifdef WB_DEC_MUX_ERRLOG_EN
    request(32'h0000_6000, CTI_CLASSIC);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("log_clr_cnt", err_cnt, 8'd0);
    chk("log_clr_adr", err_adr, 32'h0);
    idle_master();
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
